// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width, the hard-wired zero
// register and the multiplier latency used across hazard/forwarding logic.
package pipe_pkg;

    localparam int REG_W           = 5;
    localparam int MUL_LATENCY_DEF = 4;

    typedef logic [REG_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    // $zero is never a real dependency, so it can never match.
    function automatic logic addr_hit(input reg_addr_t a, input reg_addr_t b);
        return (a != REG_ZERO) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_mul_scoreboard.sv
// One-entry scoreboard for the non-blocking multiplier: tracks the in-flight
// destination and times the writeback strobe.
module mul_scoreboard
    import pipe_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int CNT_W       = 3
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              i_mul_start,
    input  logic [REG_W-1:0]  i_dest,
    output logic              o_pending,
    output logic [REG_W-1:0]  o_pend_dest,
    output logic              o_mul_wb,
    output logic [REG_W-1:0]  o_mul_wb_addr
);

    logic             r_busy;
    logic [REG_W-1:0] r_dest;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_dest <= REG_ZERO;
            r_cnt  <= '0;
        end else if (i_mul_start) begin
            r_busy <= 1'b1;
            r_dest <= i_dest;
            r_cnt  <= CNT_W'(MUL_LATENCY - 1);
        end else if (r_busy && (r_cnt != '0)) begin
            r_cnt  <= r_cnt - CNT_W'(1);
        end else if (r_busy) begin
            r_busy <= 1'b0;
        end
    end

    // The structural stall in ID must keep a second multiply out of EX.
    a_no_issue_while_busy: assert property (
        @(posedge clk_i) disable iff (!rst_n) !(i_mul_start && r_busy));

    assign o_pending     = r_busy | i_mul_start;
    assign o_pend_dest   = r_busy ? r_dest : i_dest;
    assign o_mul_wb      = r_busy & (r_cnt == '0);
    assign o_mul_wb_addr = r_dest;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush controller: load-use and multiplier hazards, branch
// flush priority, and a saturating stall-cycle counter.
module hazard_stall_unit
    import pipe_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int CNT_W       = 3,
    parameter int PERF_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  IF_ID_Rs_addr,
    input  logic [REG_W-1:0]  IF_ID_Rt_addr,
    input  logic [REG_W-1:0]  IF_ID_Rd_addr,
    input  logic              IF_ID_RegWrite,
    input  logic              IF_ID_MulOp,
    input  logic [REG_W-1:0]  ID_EX_Rt_addr,
    input  logic [REG_W-1:0]  ID_EX_Rd_addr,
    input  logic              ID_EX_MemRead,
    input  logic              ID_EX_MulStart,
    input  logic              Branch_taken,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              ID_EX_Bubble,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              Mul_WB,
    output logic [REG_W-1:0]  Mul_WB_addr,
    output logic [PERF_W-1:0] Stall_cycles
);

    logic             w_pending;
    logic [REG_W-1:0] w_pend_dest;
    logic             w_load_use;
    logic             w_mul_raw;
    logic             w_mul_waw;
    logic             w_mul_struct;
    logic             w_stall;
    logic [PERF_W-1:0] r_stall_cycles;

    mul_scoreboard #(
        .MUL_LATENCY (MUL_LATENCY),
        .CNT_W       (CNT_W)
    ) u_mul_scoreboard (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .i_mul_start   (ID_EX_MulStart),
        .i_dest        (ID_EX_Rd_addr),
        .o_pending     (w_pending),
        .o_pend_dest   (w_pend_dest),
        .o_mul_wb      (Mul_WB),
        .o_mul_wb_addr (Mul_WB_addr)
    );

    assign w_load_use   = ID_EX_MemRead &
                          (addr_hit(ID_EX_Rt_addr, IF_ID_Rs_addr) |
                           addr_hit(ID_EX_Rt_addr, IF_ID_Rt_addr));
    // RAW holds through the writeback cycle: the register file is not write-first.
    assign w_mul_raw    = w_pending &
                          (addr_hit(w_pend_dest, IF_ID_Rs_addr) |
                           addr_hit(w_pend_dest, IF_ID_Rt_addr));
    assign w_mul_waw    = w_pending & IF_ID_RegWrite & addr_hit(w_pend_dest, IF_ID_Rd_addr);
    assign w_mul_struct = w_pending & IF_ID_MulOp;

    assign w_stall = (w_load_use | w_mul_raw | w_mul_waw | w_mul_struct) & ~Branch_taken;

    assign PC_Write     = ~w_stall;
    assign IF_ID_Write  = ~w_stall;
    assign ID_EX_Bubble = w_stall;
    assign IF_ID_Flush  = Branch_taken;
    assign ID_EX_Flush  = Branch_taken;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign Stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scenarios plus randomized traffic for hazard_stall_unit, checked
// against a cycle-numbered model of the pipeline hazard rules.
module tb_hazard_stall_unit;

    localparam int LAT = 4;
    localparam int CW  = 3;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] IF_ID_Rs_addr, IF_ID_Rt_addr, IF_ID_Rd_addr;
    logic       IF_ID_RegWrite, IF_ID_MulOp;
    logic [4:0] ID_EX_Rt_addr, ID_EX_Rd_addr;
    logic       ID_EX_MemRead, ID_EX_MulStart, Branch_taken;

    logic        PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, Mul_WB;
    logic [4:0]  Mul_WB_addr;
    logic [15:0] Stall_cycles;

    logic        s_pc, s_ifw, s_bub, s_iff, s_exf, s_wb;
    logic [4:0]  s_wb_addr;
    logic [3:0]  s_stall_cycles;

    always #5 clk_i = ~clk_i;

    hazard_stall_unit #(.MUL_LATENCY(LAT), .CNT_W(CW), .PERF_W(16)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .IF_ID_Rs_addr(IF_ID_Rs_addr), .IF_ID_Rt_addr(IF_ID_Rt_addr),
        .IF_ID_Rd_addr(IF_ID_Rd_addr), .IF_ID_RegWrite(IF_ID_RegWrite),
        .IF_ID_MulOp(IF_ID_MulOp), .ID_EX_Rt_addr(ID_EX_Rt_addr),
        .ID_EX_Rd_addr(ID_EX_Rd_addr), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MulStart(ID_EX_MulStart), .Branch_taken(Branch_taken),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .Mul_WB(Mul_WB),
        .Mul_WB_addr(Mul_WB_addr), .Stall_cycles(Stall_cycles)
    );

    hazard_stall_unit #(.MUL_LATENCY(LAT), .CNT_W(CW), .PERF_W(4)) dut_sat (
        .clk_i(clk_i), .rst_n(rst_n),
        .IF_ID_Rs_addr(IF_ID_Rs_addr), .IF_ID_Rt_addr(IF_ID_Rt_addr),
        .IF_ID_Rd_addr(IF_ID_Rd_addr), .IF_ID_RegWrite(IF_ID_RegWrite),
        .IF_ID_MulOp(IF_ID_MulOp), .ID_EX_Rt_addr(ID_EX_Rt_addr),
        .ID_EX_Rd_addr(ID_EX_Rd_addr), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MulStart(ID_EX_MulStart), .Branch_taken(Branch_taken),
        .PC_Write(s_pc), .IF_ID_Write(s_ifw), .ID_EX_Bubble(s_bub),
        .IF_ID_Flush(s_iff), .ID_EX_Flush(s_exf), .Mul_WB(s_wb),
        .Mul_WB_addr(s_wb_addr), .Stall_cycles(s_stall_cycles)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: an in-flight multiply is a (dest, writeback cycle number) pair.
    int         cyc;
    bit         fl;
    int         wb_at;
    logic [4:0] fdest;
    int         sc16, sc4;
    bit         e_stall;

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input bit rw, input bit mop, input logic [4:0] exrt,
                          input logic [4:0] exrd, input bit mr, input bit ms, input bit br);
        IF_ID_Rs_addr = rs; IF_ID_Rt_addr = rt; IF_ID_Rd_addr = rd;
        IF_ID_RegWrite = rw; IF_ID_MulOp = mop;
        ID_EX_Rt_addr = exrt; ID_EX_Rd_addr = exrd;
        ID_EX_MemRead = mr; ID_EX_MulStart = ms; Branch_taken = br;
    endtask

    function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    task automatic eval_and_check;
        bit         pend, lu, raw, waw, st, wb;
        logic [4:0] pd;
        pend = fl || ID_EX_MulStart;
        pd   = fl ? fdest : ID_EX_Rd_addr;
        lu   = ID_EX_MemRead && (dep(ID_EX_Rt_addr, IF_ID_Rs_addr) || dep(ID_EX_Rt_addr, IF_ID_Rt_addr));
        raw  = pend && (dep(pd, IF_ID_Rs_addr) || dep(pd, IF_ID_Rt_addr));
        waw  = pend && IF_ID_RegWrite && dep(pd, IF_ID_Rd_addr);
        st   = pend && IF_ID_MulOp;
        e_stall = (lu || raw || waw || st) && !Branch_taken;
        wb   = fl && (cyc == wb_at);
        chk("pc_write",    PC_Write,     !e_stall);
        chk("if_id_write", IF_ID_Write,  !e_stall);
        chk("bubble",      ID_EX_Bubble, e_stall);
        chk("if_id_flush", IF_ID_Flush,  Branch_taken);
        chk("id_ex_flush", ID_EX_Flush,  Branch_taken);
        chk("mul_wb",      Mul_WB,       wb);
        chk("mul_wb_addr", Mul_WB_addr,  fdest);
        chk("stall_cnt",   Stall_cycles, sc16);
        chk("stall_cnt4",  s_stall_cycles, sc4);
    endtask

    task automatic step;
        @(posedge clk_i);
        if (e_stall) begin
            if (sc16 < 65535) sc16++;
            if (sc4 < 15) sc4++;
        end
        if (ID_EX_MulStart) begin
            fl = 1; wb_at = cyc + LAT; fdest = ID_EX_Rd_addr;
        end else if (fl && cyc == wb_at) begin
            fl = 0;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic do_reset;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        fl = 0; fdest = 5'd0; sc16 = 0; sc4 = 0;
        chk("rst_pc_write", PC_Write, 1);
        chk("rst_if_id_write", IF_ID_Write, 1);
        chk("rst_bubble", ID_EX_Bubble, 0);
        chk("rst_mul_wb", Mul_WB, 0);
        chk("rst_mul_wb_addr", Mul_WB_addr, 0);
        chk("rst_stall_cnt", Stall_cycles, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        cyc++;
    endtask

    initial begin
        cyc = 0; fl = 0; wb_at = 0; fdest = 0; sc16 = 0; sc4 = 0; e_stall = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        do_reset();

        // Load-use on $2, one cycle only, then lw $0 which never stalls.
        set_in(2, 3, 4, 1, 0, 2, 0, 1, 0, 0);
        #1 eval_and_check(); chk("lu_stall", ID_EX_Bubble, 1);
        step();
        set_in(2, 3, 4, 1, 0, 9, 0, 0, 0, 0);
        #1 eval_and_check(); chk("lu_release", ID_EX_Bubble, 0); chk("lu_count", Stall_cycles, 1);
        step();
        set_in(0, 3, 4, 1, 0, 0, 0, 1, 0, 0);
        #1 eval_and_check(); chk("lw_zero", ID_EX_Bubble, 0);
        step();

        // mul $5 at k=0, dependent reader of $5 in ID throughout.
        for (int k = 0; k < 6; k++) begin
            set_in(1, 5, 6, 1, 0, 0, 5, 0, (k == 0), 0);
            #1 eval_and_check();
            chk("raw_stall", ID_EX_Bubble, (k <= 4));
            chk("raw_wb", Mul_WB, (k == 4));
            step();
        end

        // Reset two cycles into a multiply: its writeback must never appear.
        set_in(7, 8, 9, 1, 0, 0, 6, 0, 1, 0);
        #1 eval_and_check(); step();
        set_in(7, 8, 9, 1, 0, 0, 0, 0, 0, 0);
        #1 eval_and_check(); step();
        do_reset();
        for (int k = 0; k < LAT + 2; k++) begin
            set_in(7, 8, 9, 1, 0, 0, 0, 0, 0, 0);
            #1 eval_and_check(); chk("rst_drop_wb", Mul_WB, 0);
            step();
        end

        // Branch in the writeback cycle of mul $3 with a load-use pending.
        for (int k = 0; k <= LAT; k++) begin
            if (k == LAT) set_in(3, 2, 0, 0, 0, 2, 0, 1, 0, 1);
            else          set_in(10, 11, 12, 1, 0, 0, 3, 0, (k == 0), 0);
            #1 eval_and_check();
            if (k == LAT) begin
                chk("br_flush", IF_ID_Flush, 1);
                chk("br_pc_write", PC_Write, 1);
                chk("br_bubble", ID_EX_Bubble, 0);
                chk("br_mul_wb", Mul_WB, 1);
            end
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) == 0), (!fl && $urandom_range(0, 2) == 0),
                   ($urandom_range(0, 7) == 0));
            #1 eval_and_check();
            step();
        end
        chk("sat4_final", s_stall_cycles, (sc16 >= 15) ? 15 : sc16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
